// File: rtl/t03_icache_refill_ctrl_if.sv
// Fetch, cache and instruction-bus signal bundle for the refill controller.
// The master modport is the controller's view; slave is the surrounding CPU/cache/memory.
interface t03_icache_refill_ctrl_if;
  logic        cpu_fetch_req;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_instr_valid;
  logic        cpu_stall;
  logic [31:0] lookup_addr;
  logic [31:0] next_addr;
  logic        cache_hit;
  logic        cache_next_hit;
  logic [31:0] cache_out;
  logic        cache_fill;
  logic [31:0] fill_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        fetch_err;

  modport master (
    input  cpu_fetch_req, cpu_pc, cache_hit, cache_next_hit, cache_out, mem_rdata, mem_ack,
    output cpu_instr, cpu_instr_valid, cpu_stall, lookup_addr, next_addr,
           cache_fill, fill_data, mem_req, mem_addr, fetch_err
  );

  modport slave (
    output cpu_fetch_req, cpu_pc, cache_hit, cache_next_hit, cache_out, mem_rdata, mem_ack,
    input  cpu_instr, cpu_instr_valid, cpu_stall, lookup_addr, next_addr,
           cache_fill, fill_data, mem_req, mem_addr, fetch_err
  );
endinterface

// File: rtl/t03_icache_refill_ctrl.sv
// Instruction-cache refill controller: zero-latency hits, single-word demand fills,
// optional next-word prefetch after a hit, and a bounded bus wait.
module t03_icache_refill_ctrl #(
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  t03_icache_refill_ctrl_if.master        bus
);

  localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS_REQ,
    S_MISS_FILL,
    S_PF_REQ,
    S_PF_FILL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_miss_addr;
  logic [31:0]   r_pf_addr;
  logic [31:0]   r_data_buf;
  logic [31:0]   r_pf_last;
  logic          r_pf_last_valid;
  logic [CW-1:0] r_cnt;

  logic [31:0]   w_pc_al;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_pf_target;
  logic          w_timeout;
  logic          w_start_miss;
  logic          w_start_pf;
  logic          w_capture;

  logic [31:0]   w_cpu_instr;
  logic          w_cpu_instr_valid;
  logic          w_cpu_stall;
  logic [31:0]   w_lookup_addr;
  logic [31:0]   w_next_addr;
  logic          w_cache_fill;
  logic [31:0]   w_fill_data;
  logic          w_mem_req;
  logic [31:0]   w_mem_addr;
  logic          w_fetch_err;

  assign w_pc_al     = {bus.cpu_pc[31:2], 2'b00};
  assign w_pc_plus4  = bus.cpu_pc + 32'd4;
  assign w_pf_target = {w_pc_plus4[31:2], 2'b00};
  assign w_timeout   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    w_start_miss      = 1'b0;
    w_start_pf        = 1'b0;
    w_capture         = 1'b0;
    w_cpu_instr       = 32'd0;
    w_cpu_instr_valid = 1'b0;
    w_cpu_stall       = 1'b0;
    w_lookup_addr     = 32'd0;
    w_next_addr       = 32'd0;
    w_cache_fill      = 1'b0;
    w_fill_data       = 32'd0;
    w_mem_req         = 1'b0;
    w_mem_addr        = 32'd0;
    w_fetch_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_lookup_addr = bus.cpu_pc;
        w_next_addr   = w_pc_plus4;
        if (bus.cpu_fetch_req) begin
          if (bus.cache_hit) begin
            w_cpu_instr       = bus.cache_out;
            w_cpu_instr_valid = 1'b1;
            // Skip a prefetch of the word we just fetched, even if the cache dropped it.
            if (PREFETCH_EN && !bus.cache_next_hit &&
                !(r_pf_last_valid && (r_pf_last == w_pf_target))) begin
              w_start_pf = 1'b1;
              w_next     = S_PF_REQ;
            end
          end else begin
            w_cpu_stall  = 1'b1;
            w_start_miss = 1'b1;
            w_next       = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: begin
        w_mem_req     = 1'b1;
        w_mem_addr    = r_miss_addr;
        w_lookup_addr = r_miss_addr;
        w_cpu_stall   = 1'b1;
        if (bus.mem_ack) begin
          w_capture = 1'b1;
          w_next    = S_MISS_FILL;
        end else if (w_timeout) begin
          w_fetch_err = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_MISS_FILL: begin
        w_cache_fill  = 1'b1;
        w_fill_data   = r_data_buf;
        w_lookup_addr = r_miss_addr;
        // Served from the buffer: the cache silently drops all-zero fill words.
        if (bus.cpu_fetch_req && (w_pc_al == r_miss_addr)) begin
          w_cpu_instr       = r_data_buf;
          w_cpu_instr_valid = 1'b1;
        end
        w_next = S_IDLE;
      end
      S_PF_REQ: begin
        w_mem_req     = 1'b1;
        w_mem_addr    = r_pf_addr;
        w_lookup_addr = r_pf_addr;
        w_cpu_stall   = bus.cpu_fetch_req;
        if (bus.mem_ack) begin
          w_capture = 1'b1;
          w_next    = S_PF_FILL;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_PF_FILL: begin
        w_cache_fill  = 1'b1;
        w_fill_data   = r_data_buf;
        w_lookup_addr = r_pf_addr;
        w_cpu_stall   = bus.cpu_fetch_req;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset is visible on the outputs immediately, not only after the next edge.
    if (rst) begin
      w_cpu_instr       = 32'd0;
      w_cpu_instr_valid = 1'b0;
      w_cpu_stall       = 1'b0;
      w_lookup_addr     = 32'd0;
      w_next_addr       = 32'd0;
      w_cache_fill      = 1'b0;
      w_fill_data       = 32'd0;
      w_mem_req         = 1'b0;
      w_mem_addr        = 32'd0;
      w_fetch_err       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_addr     <= 32'd0;
      r_pf_addr       <= 32'd0;
      r_data_buf      <= 32'd0;
      r_pf_last       <= 32'd0;
      r_pf_last_valid <= 1'b0;
      r_cnt           <= '0;
    end else begin
      if (w_start_miss) r_miss_addr <= w_pc_al;
      if (w_start_pf)   r_pf_addr   <= w_pf_target;
      if (w_capture)    r_data_buf  <= bus.mem_rdata;
      if (w_start_miss || w_start_pf)
        r_cnt <= '0;
      else if ((r_state == S_MISS_REQ) || (r_state == S_PF_REQ))
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_PF_FILL) begin
        r_pf_last       <= r_pf_addr;
        r_pf_last_valid <= 1'b1;
      end
    end
  end

  assign bus.cpu_instr       = w_cpu_instr;
  assign bus.cpu_instr_valid = w_cpu_instr_valid;
  assign bus.cpu_stall       = w_cpu_stall;
  assign bus.lookup_addr     = w_lookup_addr;
  assign bus.next_addr       = w_next_addr;
  assign bus.cache_fill      = w_cache_fill;
  assign bus.fill_data       = w_fill_data;
  assign bus.mem_req         = w_mem_req;
  assign bus.mem_addr        = w_mem_addr;
  assign bus.fetch_err       = w_fetch_err;

endmodule
